// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared MDU op codes, op type and controller state enum
package mdu_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t OP_NONE  = 4'd0;
  localparam mdu_op_t OP_MULT  = 4'd1;
  localparam mdu_op_t OP_MULTU = 4'd2;
  localparam mdu_op_t OP_DIV   = 4'd3;
  localparam mdu_op_t OP_DIVU  = 4'd4;
  localparam mdu_op_t OP_MFHI  = 4'd5;
  localparam mdu_op_t OP_MFLO  = 4'd6;
  localparam mdu_op_t OP_MTHI  = 4'd7;
  localparam mdu_op_t OP_MTLO  = 4'd8;
  localparam mdu_op_t OP_MADD  = 4'd9;
  localparam mdu_op_t OP_MADDU = 4'd10;
  localparam mdu_op_t OP_MSUB  = 4'd11;
  localparam mdu_op_t OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } mdu_state_t;

  // Multiply/divide ops that always start the unit.
  function automatic logic is_base_start(mdu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Multiply-accumulate family (only meaningful when accumulation is built in).
  function automatic logic is_acc_op(mdu_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // The unit only multiplies; accumulation happens at commit, so MADD-family
  // ops are sent as the plain multiply of matching signedness.
  function automatic mdu_op_t issue_op(mdu_op_t op);
    mdu_op_t r;
    case (op)
      OP_MADD, OP_MSUB:   r = OP_MULT;
      OP_MADDU, OP_MSUBU: r = OP_MULTU;
      default:            r = op;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - EX-stage controller for the multiply/divide unit; MDU_CTRL_MADD_EN adds MADD/MSUB
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  mdu_op_t         ex_op,
  input  logic [XLEN-1:0] ex_srcA,
  input  logic [XLEN-1:0] ex_srcB,
  input  logic            flush,
  output logic            ex_stall,
  output logic [XLEN-1:0] rd_data,
  output logic            mdu_in_valid,
  output mdu_op_t         mdu_op,
  output logic [XLEN-1:0] mdu_srcA,
  output logic [XLEN-1:0] mdu_srcB,
  input  logic            mdu_in_ready,
  input  logic            mdu_out_valid,
  output logic            mdu_out_ready,
  input  logic [XLEN-1:0] mdu_hi,
  input  logic [XLEN-1:0] mdu_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t      state, state_next;
  logic [XLEN-1:0] hi_next, lo_next;
  logic            start_op, mf_op, mt_op, mdu_class;

`ifdef MDU_CTRL_MADD_EN
  logic acc_q, acc_next, acc_sub_q, acc_sub_next;
`endif

  // Decode the EX op into start / move-from / move-to classes.
  always_comb begin
    start_op = ex_valid && is_base_start(ex_op);
`ifdef MDU_CTRL_MADD_EN
    if (ex_valid && is_acc_op(ex_op)) start_op = 1'b1;
`endif
    mf_op     = ex_valid && ((ex_op == OP_MFHI) || (ex_op == OP_MFLO));
    mt_op     = ex_valid && ((ex_op == OP_MTHI) || (ex_op == OP_MTLO));
    mdu_class = start_op || mf_op || mt_op;
  end

  // Request payload follows EX directly; mdu_in_valid qualifies it.
  always_comb begin
    mdu_op   = issue_op(ex_op);
    mdu_srcA = ex_srcA;
    mdu_srcB = ex_srcB;
  end

  // Next-state, HI/LO update and handshake outputs.
  always_comb begin
    state_next    = state;
    hi_next       = hi;
    lo_next       = lo;
    mdu_in_valid  = 1'b0;
    mdu_out_ready = 1'b0;
    ex_stall      = 1'b0;
    rd_data       = '0;
`ifdef MDU_CTRL_MADD_EN
    acc_next      = acc_q;
    acc_sub_next  = acc_sub_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start_op) begin
          if (!mdu_in_ready) begin
            ex_stall = 1'b1;
          end else if (!flush) begin
            mdu_in_valid = 1'b1;
            state_next   = ST_WAIT;
`ifdef MDU_CTRL_MADD_EN
            acc_next     = is_acc_op(ex_op);
            acc_sub_next = (ex_op == OP_MSUB) || (ex_op == OP_MSUBU);
`endif
          end
        end
        if (mf_op) rd_data = (ex_op == OP_MFHI) ? hi : lo;
        if (mt_op && !flush) begin
          if (ex_op == OP_MTHI) hi_next = ex_srcA;
          else                  lo_next = ex_srcA;
        end
      end
      ST_WAIT: begin
        mdu_out_ready = 1'b1;
        ex_stall      = mdu_class;
        if (mdu_out_valid) begin
          state_next = ST_IDLE;
          if (!flush) begin
`ifdef MDU_CTRL_MADD_EN
            if (acc_q && acc_sub_q)
              {hi_next, lo_next} = {hi, lo} - {mdu_hi, mdu_lo};
            else if (acc_q)
              {hi_next, lo_next} = {hi, lo} + {mdu_hi, mdu_lo};
            else
              {hi_next, lo_next} = {mdu_hi, mdu_lo};
`else
            {hi_next, lo_next} = {mdu_hi, mdu_lo};
`endif
          end
        end else if (flush) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        mdu_out_ready = 1'b1;
        ex_stall      = mdu_class;
        if (mdu_out_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) begin
      mdu_in_valid  = 1'b0;
      mdu_out_ready = 1'b0;
      ex_stall      = 1'b0;
      rd_data       = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

`ifdef MDU_CTRL_MADD_EN
  // Accumulate mode captured at issue, used at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= 1'b0;
      acc_sub_q <= 1'b0;
    end else begin
      acc_q     <= acc_next;
      acc_sub_q <= acc_sub_next;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural MDU and reference model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_CTRL_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_op = 4'd0;
  logic [31:0] ex_srcA = '0, ex_srcB = '0;
  logic        flush = 1'b0;
  logic        ex_stall, mdu_in_valid, mdu_in_ready, mdu_out_valid, mdu_out_ready;
  logic [31:0] rd_data, mdu_srcA, mdu_srcB, mdu_hi, mdu_lo, hi, lo;
  logic [3:0]  mdu_op;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .flush(flush), .ex_stall(ex_stall),
    .rd_data(rd_data), .mdu_in_valid(mdu_in_valid), .mdu_op(mdu_op),
    .mdu_srcA(mdu_srcA), .mdu_srcB(mdu_srcB), .mdu_in_ready(mdu_in_ready),
    .mdu_out_valid(mdu_out_valid), .mdu_out_ready(mdu_out_ready),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .hi(hi), .lo(lo)
  );

  // Arithmetic meaning of a plain multiply/divide op: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q, r;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q}; end
      4'd4: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural multiply/divide unit with random latency and readiness.
  logic rdy_ok, u_busy, rand_ready;
  int   u_cnt;
  assign mdu_in_ready = rdy_ok && !u_busy;

  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0; mdu_out_valid <= 1'b0; rdy_ok <= 1'b1; u_cnt <= 0;
      mdu_hi <= '0; mdu_lo <= '0;
    end else begin
      rdy_ok <= rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!u_busy) begin
        if (mdu_in_valid && mdu_in_ready) begin
          u_busy <= 1'b1;
          u_cnt  <= $urandom_range(1, 4);
          {mdu_hi, mdu_lo} <= ref_result(mdu_op, mdu_srcA, mdu_srcB);
        end
      end else if (!mdu_out_valid) begin
        if (u_cnt <= 1) mdu_out_valid <= 1'b1;
        else            u_cnt <= u_cnt - 1;
      end else if (mdu_out_ready) begin
        mdu_out_valid <= 1'b0;
        u_busy        <= 1'b0;
      end
    end
  end

  // Reference model: pending-result bookkeeping and architectural HI/LO.
  logic        m_busy = 1'b0, m_discard = 1'b0;
  int          m_acc = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic logic is_start(input logic v, input logic [3:0] op);
    return v && ((op >= 4'd1 && op <= 4'd4) || (MADD_EN && op >= 4'd9 && op <= 4'd12));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply inputs mid-cycle and check every combinational output and HI/LO.
  task automatic drive(input logic rst, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic st, mf, mt, e_inv, e_stall;
    logic [31:0] e_rd;
    logic [3:0]  e_op;
    @(negedge clk);
    reset = rst; ex_valid = v; ex_op = op; ex_srcA = a; ex_srcB = b; flush = fl;
    #1;
    st = is_start(v, op);
    mf = v && (op == 4'd5 || op == 4'd6);
    mt = v && (op == 4'd7 || op == 4'd8);
    e_rd = '0; e_inv = 1'b0; e_stall = 1'b0;
    if (!m_busy) begin
      e_inv   = st && mdu_in_ready && !fl;
      e_stall = st && !mdu_in_ready;
      if (mf) e_rd = (op == 4'd5) ? m_hi : m_lo;
    end else begin
      e_stall = st || mf || mt;
    end
    if (rst) begin e_inv = 1'b0; e_stall = 1'b0; e_rd = '0; end
    chk("ex_stall", ex_stall, e_stall);
    chk("mdu_in_valid", mdu_in_valid, e_inv);
    chk("rd_data", rd_data, e_rd);
    chk("mdu_out_ready", mdu_out_ready, !rst && m_busy);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (e_inv) begin
      e_op = (op == 4'd9 || op == 4'd11) ? 4'd1 : (op == 4'd10 || op == 4'd12) ? 4'd2 : op;
      chk("mdu_op", mdu_op, e_op);
      chk("mdu_srcA", mdu_srcA, a);
      chk("mdu_srcB", mdu_srcB, b);
    end
  endtask

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic tick();
    logic ov, rdy;
    logic [3:0] base;
    ov = mdu_out_valid; rdy = mdu_in_ready;
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_discard = 1'b0; m_acc = 0; m_hi = '0; m_lo = '0;
    end else if (!m_busy) begin
      if (is_start(ex_valid, ex_op) && rdy && !flush) begin
        base = (ex_op == 4'd9 || ex_op == 4'd11) ? 4'd1 :
               (ex_op == 4'd10 || ex_op == 4'd12) ? 4'd2 : ex_op;
        m_res = ref_result(base, ex_srcA, ex_srcB);
        m_acc = (ex_op == 4'd9 || ex_op == 4'd10) ? 1 : (ex_op == 4'd11 || ex_op == 4'd12) ? 2 : 0;
        m_busy = 1'b1; m_discard = 1'b0;
      end else if (ex_valid && !flush && ex_op == 4'd7) m_hi = ex_srcA;
      else if (ex_valid && !flush && ex_op == 4'd8) m_lo = ex_srcA;
    end else if (ov) begin
      if (!m_discard && !flush) begin
        if (m_acc == 1)      {m_hi, m_lo} = {m_hi, m_lo} + m_res;
        else if (m_acc == 2) {m_hi, m_lo} = {m_hi, m_lo} - m_res;
        else                 {m_hi, m_lo} = m_res;
      end
      m_busy = 1'b0;
    end else if (flush) m_discard = 1'b1;
  endtask

  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic fl);
    drive(rst, v, op, a, b, fl);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && m_busy; i++) step(0, 0, 4'd0, 0, 0, 0);
    chk(tag, m_busy, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    rand_ready = 1'b0;

    // Reset state
    step(1, 0, 4'd0, 0, 0, 0);
    step(1, 1, OP_MULT, 7, 9, 0);
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_out_ready", mdu_out_ready, 1'b0);
    tick();

    // Signed versus unsigned multiply
    step(0, 1, OP_MULT, 32'hFFFFFFFF, 32'h2, 0);
    wait_idle("mult_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    tick();
    step(0, 1, OP_MULTU, 32'hFFFFFFFF, 32'h2, 0);
    wait_idle("multu_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    tick();

    // Signed divide, MFLO stalls until the cycle after completion
    drive(0, 1, OP_DIV, 32'hFFFFFFF9, 32'h2, 0);
    chk("div_no_stall", ex_stall, 1'b0);
    tick();
    for (int i = 0; i < 40 && m_busy; i++) step(0, 1, OP_MFLO, 0, 0, 0);
    drive(0, 1, OP_MFLO, 0, 0, 0);
    chk("div_mflo_stall", ex_stall, 1'b0);
    chk("div_mflo_rd", rd_data, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    tick();

    // Flushed divide is discarded
    step(0, 1, OP_MTHI, 32'h11111111, 0, 0);
    step(0, 1, OP_MTLO, 32'h22222222, 0, 0);
    step(0, 1, OP_DIVU, 32'h100, 32'h3, 0);
    step(0, 0, 4'd0, 0, 0, 1);
    wait_idle("drain_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("drain_hi", hi, 32'h11111111);
    chk("drain_lo", lo, 32'h22222222);
    tick();

    // MT then MF back-to-back, no bypass stall
    step(0, 1, OP_MTHI, 32'hA5A5A5A5, 0, 0);
    drive(0, 1, OP_MFHI, 0, 0, 0);
    chk("mthi_mfhi_rd", rd_data, 32'hA5A5A5A5);
    chk("mthi_mfhi_stall", ex_stall, 1'b0);
    tick();

    // Reset while a divide is pending
    step(0, 1, OP_DIV, 32'h1000, 32'h7, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    tick();
    step(0, 1, OP_MULTU, 3, 5, 0);
    wait_idle("rst_multu_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("rst_multu_lo", lo, 32'h0000000F);
    tick();

    // Multiply-accumulate (or no-op without the feature)
    step(0, 1, OP_MTHI, 0, 0, 0);
    step(0, 1, OP_MTLO, 5, 0, 0);
    drive(0, 1, OP_MADD, 3, 4, 0);
    chk("madd_stall", ex_stall, 1'b0);
    tick();
    wait_idle("madd_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("madd_lo", lo, MADD_EN ? 32'h11 : 32'h5);
    chk("madd_hi", hi, 32'h0);
    tick();
    step(0, 1, OP_MSUB, 32'h11, 1, 0);
    wait_idle("msub_wait");
    drive(0, 0, 4'd0, 0, 0, 0);
    chk("msub_lo", lo, MADD_EN ? 32'h0 : 32'h5);
    tick();

    // Randomized traffic against the reference model
    rand_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (b == 0) b = 1;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, op, a, b,
           $urandom_range(0, 9) == 0);
    end
    rand_ready = 1'b0;
    wait_idle("final_wait");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
